// File: rtl/snake_pkg.sv
`default_nettype none
// ============================================================================
// snake_pkg
// Shared board constants, tile codes and scheduler state encoding.
// Rev 1.0 - initial release
// ============================================================================
package snake_pkg;

  localparam int BOARD_COLS      = 40;
  localparam int BOARD_ROWS      = 30;
  localparam int BOARD_CELLS     = BOARD_COLS * BOARD_ROWS;
  localparam int BOARD_ADDR_BITS = 11;
  localparam int TILE_BITS       = 4;
  localparam int FRAME_CNT_BITS  = 4;

  typedef enum logic [TILE_BITS-1:0] {
    TILE_EMPTY = 4'd0,
    TILE_HEAD  = 4'd1,
    TILE_BODY  = 4'd2,
    TILE_FOOD  = 4'd3,
    TILE_WALL  = 4'd4
  } tile_t;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_UPDATE = 1'b1
  } sched_state_t;

  // Frames per game step; a speed of 0 behaves like 1.
  function automatic logic [FRAME_CNT_BITS-1:0] eff_div(input logic [FRAME_CNT_BITS-1:0] speed);
    return (speed == '0) ? FRAME_CNT_BITS'(1) : speed;
  endfunction

endpackage
`default_nettype wire

// File: rtl/snake_frame_ticker.sv
`default_nettype none
// ============================================================================
// snake_frame_ticker
// Detects vsync rising edges and divides them down to a game-step tick.
// Rev 1.0 - initial release
// ============================================================================
module snake_frame_ticker
  import snake_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      i_vsync,
  input  logic [FRAME_CNT_BITS-1:0] i_speed,
  output logic                      o_tick
);

  logic                      r_vsync_q;
  logic [FRAME_CNT_BITS-1:0] r_frame_cnt;
  logic                      w_edge;
  logic                      w_wrap;
  logic [FRAME_CNT_BITS-1:0] w_last;

  // ">=" rather than "==" so lowering speed below the current count
  // still produces a tick on the very next edge.
  assign w_edge = i_vsync & ~r_vsync_q;
  assign w_last = eff_div(i_speed) - FRAME_CNT_BITS'(1);
  assign w_wrap = (r_frame_cnt >= w_last);
  assign o_tick = w_edge & w_wrap;

  // Edge history and frame counter, advanced once per vsync edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_vsync_q   <= 1'b0;
      r_frame_cnt <= '0;
    end else begin
      r_vsync_q <= i_vsync;
      if (w_edge) begin
        r_frame_cnt <= w_wrap ? '0 : r_frame_cnt + FRAME_CNT_BITS'(1);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/snake_board_sched.sv
`default_nettype none
// ============================================================================
// snake_board_sched
// Step scheduler and board-RAM arbiter: video reads win, the engine is only
// granted while an update is in progress.
// Rev 1.0 - initial release
// ============================================================================
module snake_board_sched
  import snake_pkg::*;
#(
  parameter int C_addr_bits = 11,
  parameter int C_data_bits = 4
) (
  input  logic                   clk_pixel,
  input  logic                   reset,
  input  logic                   in_vsync,
  input  logic [3:0]             speed,
  output logic                   step,
  output logic                   busy,
  output logic                   overrun,
  input  logic                   gm_done,
  input  logic                   vid_req,
  input  logic [C_addr_bits-1:0] vid_addr,
  output logic [C_data_bits-1:0] vid_rdata,
  output logic                   vid_rvalid,
  input  logic                   gm_req,
  input  logic                   gm_we,
  input  logic [C_addr_bits-1:0] gm_addr,
  input  logic [C_data_bits-1:0] gm_wdata,
  output logic                   gm_ack,
  output logic [C_data_bits-1:0] gm_rdata,
  output logic                   gm_rvalid,
  output logic                   ram_en,
  output logic                   ram_we,
  output logic [C_addr_bits-1:0] ram_addr,
  output logic [C_data_bits-1:0] ram_wdata,
  input  logic [C_data_bits-1:0] ram_rdata
);

  sched_state_t           r_state;
  logic                   r_step;
  logic                   r_busy;
  logic                   r_overrun;
  logic                   r_rd_pend;
  logic                   r_rd_gm;
  logic [C_addr_bits-1:0] r_addr_q;
  logic [C_data_bits-1:0] r_wdata_q;

  logic w_tick;
  logic w_vid_issue;
  logic w_gm_issue;
  logic w_ret_ok;

  snake_frame_ticker u_ticker (
    .clk     (clk_pixel),
    .rst     (reset),
    .i_vsync (in_vsync),
    .i_speed (speed),
    .o_tick  (w_tick)
  );

  // Grants are masked during reset so every output reads 0 while it is held.
  assign w_vid_issue = vid_req & ~reset;
  assign w_gm_issue  = gm_req & ~vid_req & r_busy & ~reset;
  assign gm_ack      = w_gm_issue;

  // IDLE/UPDATE step control; gm_done beats a coincident tick.
  always_ff @(posedge clk_pixel) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_step    <= 1'b0;
      r_busy    <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      r_step <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_tick) begin
            r_step  <= 1'b1;
            r_busy  <= 1'b1;
            r_state <= ST_UPDATE;
          end
        end
        ST_UPDATE: begin
          if (gm_done) begin
            r_busy  <= 1'b0;
            r_state <= ST_IDLE;
          end else if (w_tick) begin
            r_overrun <= 1'b1;
          end
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign step    = r_step;
  assign busy    = r_busy;
  assign overrun = r_overrun;

  // Read-return tracking plus the address/data hold used on idle cycles.
  always_ff @(posedge clk_pixel) begin
    if (reset) begin
      r_rd_pend <= 1'b0;
      r_rd_gm   <= 1'b0;
      r_addr_q  <= '0;
      r_wdata_q <= '0;
    end else begin
      r_rd_pend <= w_vid_issue | (w_gm_issue & ~gm_we);
      r_rd_gm   <= w_gm_issue;
      if (w_vid_issue) begin
        r_addr_q <= vid_addr;
      end else if (w_gm_issue) begin
        r_addr_q  <= gm_addr;
        r_wdata_q <= gm_wdata;
      end
    end
  end

  // RAM port mux: video first, then a granted engine op, else hold.
  always_comb begin
    ram_en    = 1'b0;
    ram_we    = 1'b0;
    ram_addr  = r_addr_q;
    ram_wdata = r_wdata_q;
    if (w_vid_issue) begin
      ram_en   = 1'b1;
      ram_addr = vid_addr;
    end else if (w_gm_issue) begin
      ram_en    = 1'b1;
      ram_we    = gm_we;
      ram_addr  = gm_addr;
      ram_wdata = gm_wdata;
    end
  end

  // A return in flight when reset arrives is discarded.
  assign w_ret_ok   = r_rd_pend & ~reset;
  assign vid_rvalid = w_ret_ok & ~r_rd_gm;
  assign gm_rvalid  = w_ret_ok & r_rd_gm;
  assign vid_rdata  = vid_rvalid ? ram_rdata : '0;
  assign gm_rdata   = gm_rvalid ? ram_rdata : '0;

endmodule
`default_nettype wire
